// File: rtl/alu_pkg.sv
// Shared ALU definitions: default widths, opcode encodings and the command word.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package alu_pkg;

   localparam int ALU_DATA_W = 32;
   localparam int ALU_SEL_W  = 3;

   typedef enum logic [ALU_SEL_W-1:0] {
      OP_NOP  = 3'b000,
      OP_ADD  = 3'b001,
      OP_AND  = 3'b010,
      OP_OR   = 3'b011,
      OP_MUL  = 3'b100,
      OP_SUB  = 3'b101,
      OP_SLT  = 3'b110,
      OP_RSVD = 3'b111
   } op_e;

   // One queued ALU operation as it sits in the command FIFO.
   typedef struct packed {
      logic [ALU_DATA_W-1:0] a;
      logic [ALU_DATA_W-1:0] b;
      logic [ALU_SEL_W-1:0]  sel;
   } cmd_t;

endpackage

// File: rtl/alu_cmd_issue_if.sv
// Command-in and result-out handshake bundle for the ALU issue stage.
// Latency: none (wires only).
// Backpressure: in_ready throttles the producer, out_ready stalls the result register.
interface alu_cmd_issue_if #(
   parameter int DATA_W = 32,
   parameter int SEL_W  = 3
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_a;
   logic [DATA_W-1:0] in_b;
   logic [SEL_W-1:0]  in_sel;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_r;
   logic              out_z;
   logic [SEL_W-1:0]  out_sel;

   // Producer/consumer side.
   modport master (
      output in_valid, in_a, in_b, in_sel, out_ready,
      input  in_ready, out_valid, out_r, out_z, out_sel
   );

   // Issue stage side.
   modport slave (
      input  in_valid, in_a, in_b, in_sel, out_ready,
      output in_ready, out_valid, out_r, out_z, out_sel
   );
endinterface

// File: rtl/alub.sv
// Combinational 32-bit ALU fed by the issue stage; Z flags an all-zero result.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the result follows A/B/sel continuously.
module alub
   import alu_pkg::*;
#(
   parameter int DATA_W = ALU_DATA_W,
   parameter int SEL_W  = ALU_SEL_W
) (
   input  logic [DATA_W-1:0] A,
   input  logic [DATA_W-1:0] B,
   input  logic [SEL_W-1:0]  sel,
   output logic [DATA_W-1:0] R,
   output logic              Z
);

   // Opcode decode; NOP and the reserved code both yield zero.
   always_comb begin
      R = '0;
      case (sel)
         OP_ADD:  R = A + B;
         OP_AND:  R = A & B;
         OP_OR:   R = A | B;
         OP_MUL:  R = A * B;
         OP_SUB:  R = A - B;
         OP_SLT:  R = {{(DATA_W-1){1'b0}}, ($signed(A) < $signed(B))};
         default: R = '0;
      endcase
   end

   assign Z = (R == '0);

endmodule

// File: rtl/cmd_fifo.sv
// Generic synchronous FIFO with power-of-two depth and first-word-fall-through read.
// Latency: a pushed word is visible at pop_dat one cycle after the push edge.
// Backpressure: pushes while full and pops while empty are ignored; no full-bypass.
module cmd_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_dat,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_dat,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign pop_dat = mem[rd_ptr];

   // Storage array; contents need no reset because count guards every read.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_dat;
   end

   // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/alu_cmd_issue.sv
// Command-issue front end for the ALU: FIFO -> issue register (A/B/sel) -> result register.
// Latency: 2 cycles from accept to out_valid; one result per cycle sustained.
// Backpressure: out_ready low freezes the result register, then the issue register, then fills the FIFO.
module alu_cmd_issue
   import alu_pkg::*;
#(
   // cmd_t takes its field widths from alu_pkg, so widths are changed there.
   parameter int DATA_W = ALU_DATA_W,
   parameter int SEL_W  = ALU_SEL_W,
   parameter int DEPTH  = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   alu_cmd_issue_if.slave         io,
   output logic [DATA_W-1:0]      A,
   output logic [DATA_W-1:0]      B,
   output logic [SEL_W-1:0]       sel,
   input  logic [DATA_W-1:0]      R,
   input  logic                   Z,
   output logic [$clog2(DEPTH):0] count
);

   cmd_t              push_cmd;
   cmd_t              head;
   logic              full;
   logic              empty;
   logic              pop;
   logic              issue_valid;
   logic              res_stall;
   logic              issue_adv;
   logic              out_valid;
   logic [DATA_W-1:0] out_r;
   logic              out_z;
   logic [SEL_W-1:0]  out_sel;

   assign push_cmd.a   = io.in_a;
   assign push_cmd.b   = io.in_b;
   assign push_cmd.sel = io.in_sel;

   assign io.in_ready  = !full;
   assign io.out_valid = out_valid;
   assign io.out_r     = out_r;
   assign io.out_z     = out_z;
   assign io.out_sel   = out_sel;

   // The issue register may move whenever it is empty or its result can be captured.
   assign res_stall = out_valid && !io.out_ready;
   assign issue_adv = !issue_valid || !res_stall;
   assign pop       = issue_adv && !empty;

   cmd_fifo #(
      .WIDTH ($bits(cmd_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (io.in_valid),
      .push_dat (push_cmd),
      .pop      (pop),
      .pop_dat  (head),
      .full     (full),
      .empty    (empty),
      .count    (count)
   );

   // Issue register: load the FIFO head on advance; operands hold while idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         issue_valid <= 1'b0;
         A           <= '0;
         B           <= '0;
         sel         <= '0;
      end else if (issue_adv) begin
         if (!empty) begin
            A           <= head.a;
            B           <= head.b;
            sel         <= head.sel;
            issue_valid <= 1'b1;
         end else begin
            issue_valid <= 1'b0;
         end
      end
   end

   // Result register: capture the ALU output unless the consumer is stalling us.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_r     <= '0;
         out_z     <= 1'b0;
         out_sel   <= '0;
      end else if (issue_valid && !res_stall) begin
         out_valid <= 1'b1;
         out_r     <= R;
         out_z     <= Z;
         out_sel   <= sel;
      end else if (io.out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Directed bench for alu_cmd_issue driving the real alub, with an in-order result scoreboard.
// Latency: checks the 2-cycle accept-to-result path and 1/cycle streaming.
// Backpressure: exercises full FIFO refusal, held outputs and mid-flight reset.
module tb_alu_cmd_issue;
   import alu_pkg::*;

   typedef struct {
      logic [31:0] r;
      logic        z;
      logic [2:0]  sel;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [31:0] A;
   logic [31:0] B;
   logic [2:0]  sel;
   logic [31:0] R;
   logic        Z;
   logic [2:0]  count;

   int          vectors;
   int          miscompares;
   int          n_out;
   logic [31:0] cur_exp_r;
   exp_t        sb[$];

   alu_cmd_issue_if #(.DATA_W(32), .SEL_W(3)) bus ();

   alu_cmd_issue #(.DATA_W(32), .SEL_W(3), .DEPTH(4)) dut (
      .clk   (clk),
      .rst   (rst),
      .io    (bus),
      .A     (A),
      .B     (B),
      .sel   (sel),
      .R     (R),
      .Z     (Z),
      .count (count)
   );

   alub #(.DATA_W(32), .SEL_W(3)) u_alu (
      .A   (A),
      .B   (B),
      .sel (sel),
      .R   (R),
      .Z   (Z)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: record accepted commands, compare every emitted result in order.
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
      end else begin
         if (bus.out_valid && bus.out_ready) begin
            exp_t e;
            n_out++;
            chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk("sb_out_r", 64'(bus.out_r), 64'(e.r));
               chk("sb_out_z", 64'(bus.out_z), 64'(e.z));
               chk("sb_out_sel", 64'(bus.out_sel), 64'(e.sel));
            end
         end
         if (bus.in_valid && bus.in_ready)
            sb.push_back('{r: cur_exp_r, z: (cur_exp_r == 32'd0), sel: bus.in_sel});
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] sa [6];
      logic [31:0] sbv[6];
      logic [2:0]  ss [6];
      logic [31:0] sr [6];
      int          base;
      int          acc;

      sa  = '{32'h10, 32'h1, 32'h8,  32'h4,  32'h10, 32'h5};
      sbv = '{32'h20, 32'hF, 32'hFF, 32'h5,  32'h5,  32'h10};
      ss  = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110};
      sr  = '{32'h30, 32'h1, 32'hFF, 32'h14, 32'hB,  32'h1};

      vectors       = 0;
      miscompares   = 0;
      n_out         = 0;
      cur_exp_r     = '0;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_sel    = '0;
      bus.out_ready = 1'b0;

      // Reset
      repeat (2) tick();
      rst = 1'b0;
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_A", 64'(A), 64'd0);
      chk("rst_B", 64'(B), 64'd0);
      chk("rst_sel", 64'(sel), 64'd0);

      // Single op latency
      bus.out_ready = 1'b1;
      bus.in_a      = 32'h10;
      bus.in_b      = 32'h20;
      bus.in_sel    = OP_ADD;
      cur_exp_r     = 32'h30;
      bus.in_valid  = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      chk("lat_t0_out_valid", 64'(bus.out_valid), 64'd0);
      tick();
      chk("lat_t1_out_valid", 64'(bus.out_valid), 64'd0);
      chk("lat_t1_A", 64'(A), 64'h10);
      chk("lat_t1_B", 64'(B), 64'h20);
      chk("lat_t1_sel", 64'(sel), 64'd1);
      tick();
      chk("lat_t2_out_valid", 64'(bus.out_valid), 64'd1);
      chk("lat_out_r", 64'(bus.out_r), 64'h30);
      chk("lat_out_z", 64'(bus.out_z), 64'd0);
      chk("lat_out_sel", 64'(bus.out_sel), 64'd1);
      tick();

      // Back-to-back stream
      base = n_out;
      for (int i = 0; i < 6; i++) begin
         bus.in_a     = sa[i];
         bus.in_b     = sbv[i];
         bus.in_sel   = ss[i];
         cur_exp_r    = sr[i];
         bus.in_valid = 1'b1;
         chk("stream_in_ready", 64'(bus.in_ready), 64'd1);
         tick();
      end
      bus.in_valid = 1'b0;
      tick();
      tick();
      @(negedge clk);
      #1;
      chk("stream_results", 64'(n_out - base), 64'd6);
      chk("stream_sb_empty", 64'(sb.size()), 64'd0);
      tick();

      // Back-pressure: 8 offered, FIFO + issue + result hold 6
      bus.out_ready = 1'b0;
      acc = 0;
      for (int i = 0; i < 8; i++) begin
         bus.in_a     = 32'(i);
         bus.in_b     = 32'd100;
         bus.in_sel   = OP_ADD;
         cur_exp_r    = 32'(i + 100);
         bus.in_valid = 1'b1;
         if (bus.in_ready) acc++;
         tick();
      end
      bus.in_valid = 1'b0;
      chk("bp_accepted", 64'(acc), 64'd6);
      chk("bp_count", 64'(count), 64'd4);
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_out_r", 64'(bus.out_r), 64'd100);
      chk("bp_out_sel", 64'(bus.out_sel), 64'd1);
      repeat (3) tick();
      chk("bp_hold_out_r", 64'(bus.out_r), 64'd100);
      chk("bp_hold_out_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_hold_count", 64'(count), 64'd4);
      base = n_out;
      bus.out_ready = 1'b1;
      for (int k = 0; k < 40 && sb.size() != 0; k++) tick();
      chk("bp_drain_sb", 64'(sb.size()), 64'd0);
      chk("bp_drain_results", 64'(n_out - base), 64'd6);
      chk("bp_drain_count", 64'(count), 64'd0);
      tick();

      // Reserved opcode
      bus.in_a     = 32'hFFFF_FFFF;
      bus.in_b     = 32'hFFFF_FFFF;
      bus.in_sel   = OP_RSVD;
      cur_exp_r    = 32'd0;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick();
      tick();
      chk("rsvd_out_valid", 64'(bus.out_valid), 64'd1);
      chk("rsvd_out_r", 64'(bus.out_r), 64'd0);
      chk("rsvd_out_z", 64'(bus.out_z), 64'd1);
      chk("rsvd_out_sel", 64'(bus.out_sel), 64'd7);
      tick();
      tick();

      // Reset mid-operation
      bus.out_ready = 1'b0;
      base = n_out;
      for (int i = 0; i < 3; i++) begin
         bus.in_a     = 32'(7 + i);
         bus.in_b     = 32'd1;
         bus.in_sel   = OP_ADD;
         cur_exp_r    = 32'(8 + i);
         bus.in_valid = 1'b1;
         tick();
      end
      bus.in_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("mid_rst_count", 64'(count), 64'd0);
      chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
      bus.out_ready = 1'b1;
      bus.in_a      = 32'd2;
      bus.in_b      = 32'd3;
      bus.in_sel    = OP_ADD;
      cur_exp_r     = 32'd5;
      bus.in_valid  = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick();
      chk("mid_t1_out_valid", 64'(bus.out_valid), 64'd0);
      tick();
      chk("mid_t2_out_valid", 64'(bus.out_valid), 64'd1);
      chk("mid_out_r", 64'(bus.out_r), 64'd5);
      tick();
      tick();
      chk("mid_results", 64'(n_out - base), 64'd1);
      chk("mid_sb_empty", 64'(sb.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
